sha256_compressor: RTL and testbench

- Iterative SHA-256 compression core: executes one compression round per clock on the eight working variables a..h.
- Consumes one schedule word W_IN and one round constant K_IN per cycle, indexed by round number I.
- Sits between the message-schedule/K-ROM logic, which supplies W_IN and K_IN combinationally from I, and the digest-update stage, which adds a..h to H after round 63.
- Does not perform the final H addition.

---
 rtl/sha256_pkg.sv | 43 ++++
 rtl/sha256_round.sv | 20 ++
 rtl/sha256_compressor.sv | 52 +++++
 tb/tb_sha256_compressor.sv | 123 ++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// sha256_pkg: SHA-256 word type, round functions, initial hash values and round constants.
package sha256_pkg;

    typedef logic [31:0] word_t;
    typedef word_t [7:0] state_t;

    function automatic word_t rotr(input word_t x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    function automatic word_t big_sigma0(input word_t x);
        return rotr(x, 2) ^ rotr(x, 13) ^ rotr(x, 22);
    endfunction

    function automatic word_t big_sigma1(input word_t x);
        return rotr(x, 6) ^ rotr(x, 11) ^ rotr(x, 25);
    endfunction

    function automatic word_t ch(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (~x & z);
    endfunction

    function automatic word_t maj(input word_t x, input word_t y, input word_t z);
        return (x & y) ^ (x & z) ^ (y & z);
    endfunction

    localparam word_t IV [8] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    localparam word_t K [64] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

endpackage

// File: rtl/sha256_round.sv
// sha256_round: one combinational SHA-256 compression round; state index 0 is a, index 7 is h.
module sha256_round
    import sha256_pkg::*;
(
    input  state_t i_state,
    input  word_t  i_k,
    input  word_t  i_w,
    output state_t o_state
);

    word_t w_t1, w_t2;

    always_comb begin
        w_t1 = i_state[7] + big_sigma1(i_state[4]) + ch(i_state[4], i_state[5], i_state[6]) + i_k + i_w;
        w_t2 = big_sigma0(i_state[0]) + maj(i_state[0], i_state[1], i_state[2]);
        o_state = {i_state[6], i_state[5], i_state[4], i_state[3] + w_t1,
                   i_state[2], i_state[1], i_state[0], w_t1 + w_t2};
    end

endmodule

// File: rtl/sha256_compressor.sv
// sha256_compressor: iterative SHA-256 compression, one round per enabled edge.
// Round 0 always sources its state from H, so a new block can start without a reset.
module sha256_compressor
    import sha256_pkg::*;
(
    input  logic        CLK,
    input  logic        RESET,
    input  logic        EN,
    input  logic [5:0]  I,
    input  logic [31:0] W_IN,
    input  logic [31:0] K_IN,
    input  logic [31:0] H0,
    input  logic [31:0] H1,
    input  logic [31:0] H2,
    input  logic [31:0] H3,
    input  logic [31:0] H4,
    input  logic [31:0] H5,
    input  logic [31:0] H6,
    input  logic [31:0] H7,
    output logic [31:0] a,
    output logic [31:0] b,
    output logic [31:0] c,
    output logic [31:0] d,
    output logic [31:0] e,
    output logic [31:0] f,
    output logic [31:0] g,
    output logic [31:0] h
);

    state_t r_state;
    state_t w_h, w_src, w_next;

    assign w_h   = {H7, H6, H5, H4, H3, H2, H1, H0};
    assign w_src = (I == 6'd0) ? w_h : r_state;

    sha256_round u_round (
        .i_state (w_src),
        .i_k     (K_IN),
        .i_w     (W_IN),
        .o_state (w_next)
    );

    always_ff @(posedge CLK) begin
        if (RESET)
            r_state <= w_h;
        else if (EN)
            r_state <= w_next;
    end

    assign {h, g, f, e, d, c, b, a} = r_state;

endmodule

// File: tb/tb_sha256_compressor.sv
// tb_sha256_compressor: directed checks of reset load, single round, full 64-round run, hold, abort and restart.
module tb_sha256_compressor;
    import sha256_pkg::*;

    typedef word_t st_t [8];

    logic       CLK = 1'b0;
    logic       RESET, EN;
    logic [5:0] I;
    word_t      W_IN, K_IN;
    word_t      H [8];
    word_t      a, b, c, d, e, f, g, h;

    int n_tests = 0;
    int n_fail  = 0;

    word_t wv [64];
    st_t   iv_st, m, final_st, saved, exp_st;

    sha256_compressor dut (
        .CLK(CLK), .RESET(RESET), .EN(EN), .I(I), .W_IN(W_IN), .K_IN(K_IN),
        .H0(H[0]), .H1(H[1]), .H2(H[2]), .H3(H[3]), .H4(H[4]), .H5(H[5]), .H6(H[6]), .H7(H[7]),
        .a(a), .b(b), .c(c), .d(d), .e(e), .f(f), .g(g), .h(h)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input word_t got, input word_t exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    task automatic chk_state(input string tag, input st_t exp);
        word_t got [8];
        got = '{a, b, c, d, e, f, g, h};
        for (int j = 0; j < 8; j++)
            chk($sformatf("%s.%s", tag, string'(8'("a" + j))), got[j], exp[j]);
    endtask

    // Independent reference round on an unpacked a..h array.
    function automatic word_t rr(input word_t x, input int n);
        return {x, x} >> n;
    endfunction

    function automatic st_t mround(input st_t s, input word_t w, input word_t k);
        word_t t1, t2;
        st_t   r;
        t1 = s[7] + (rr(s[4], 6) ^ rr(s[4], 11) ^ rr(s[4], 25)) + ((s[4] & s[5]) | (~s[4] & s[6])) + k + w;
        t2 = (rr(s[0], 2) ^ rr(s[0], 13) ^ rr(s[0], 22)) + ((s[0] & s[1]) | (s[2] & (s[0] | s[1])));
        r = '{t1 + t2, s[0], s[1], s[2], s[3] + t1, s[4], s[5], s[6]};
        return r;
    endfunction

    task automatic step(input logic rst, input logic en, input int idx, input word_t w, input word_t k);
        RESET = rst;
        EN    = en;
        I     = 6'(idx);
        W_IN  = w;
        K_IN  = k;
        @(posedge CLK);
        #1;
    endtask

    task automatic run_rounds(input int from, input int to);
        for (int r = from; r <= to; r++)
            step(1'b0, 1'b1, r, wv[r], K[r]);
    endtask

    initial begin
        iv_st = '{32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
                  32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19};
        for (int j = 0; j < 64; j++) wv[j] = '0;
        wv[0] = 32'h48656c6c; wv[1] = 32'h6f20776f; wv[2] = 32'h726c6421;
        wv[3] = 32'h80000000; wv[15] = 32'h00000060;
        m = iv_st;
        for (int j = 0; j < 64; j++) m = mround(m, wv[j], K[j]);
        final_st = m;

        H = '{32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444,
              32'h55555555, 32'h66666666, 32'h77777777, 32'h88888888};
        RESET = 1'b0; EN = 1'b0; I = '0; W_IN = '0; K_IN = '0;
        @(negedge CLK);
        step(1'b1, 1'b0, 0, '0, '0);
        chk_state("rst_pattern", H);

        H = iv_st;
        step(1'b1, 1'b1, 5, 32'hdeadbeef, 32'hcafef00d);
        chk_state("rst_iv", iv_st);

        step(1'b0, 1'b1, 0, 32'h61626380, 32'h428a2f98);
        chk_state("abc_r0", '{32'h5d6aebcd, 32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372,
                               32'hfa2a4622, 32'h510e527f, 32'h9b05688c, 32'h1f83d9ab});

        run_rounds(0, 0);
        chk_state("full_r0", mround(iv_st, wv[0], K[0]));
        run_rounds(1, 63);
        chk_state("full", final_st);

        saved = final_st;
        for (int j = 0; j < 10; j++)
            step(1'b0, 1'b0, j % 2 ? 0 : 17, 32'hffffffff, 32'h12345678);
        chk_state("hold", saved);

        run_rounds(0, 29);
        step(1'b1, 1'b1, 30, wv[30], K[30]);
        chk_state("abort", iv_st);
        run_rounds(0, 63);
        chk_state("rerun", final_st);

        step(1'b0, 1'b1, 0, wv[0], K[0]);
        exp_st = mround(iv_st, wv[0], K[0]);
        chk_state("restart", exp_st);
        step(1'b0, 1'b1, 1, wv[1], K[1]);
        chk_state("restart_r1", mround(exp_st, wv[1], K[1]));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
